// File: rtl/store_access_ctrl.sv
// store_access_ctrl: sequences CPU stores to memory, using read-modify-write for sb/sh.
module store_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_req,
  input  logic [5:0]  st_opcode,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_regword,
  output logic        st_ready,
  output logic        st_done,
  output logic        st_err,
  output logic        cpu_stall,
  output logic [5:0]  merge_opcode,
  output logic [31:0] merge_addr,
  output logic [31:0] merge_regword,
  output logic [31:0] merge_dataword,
  input  logic [31:0] merge_storedata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic [31:0] addr_q, addr_d, regword_q, regword_d, dataword_q, dataword_d, writedata_q, writedata_d;
  logic err_q, err_d, is_sb, is_sh, is_sw, bad;
  assign is_sb = st_opcode == 6'b101000;
  assign is_sh = st_opcode == 6'b101001;
  assign is_sw = st_opcode == 6'b101011;
  assign bad = !(is_sb || (is_sh && !st_addr[0]) || (is_sw && st_addr[1:0] == 2'b00));
  always_comb begin
    state_d = state_q;
    opcode_d = opcode_q;
    addr_d = addr_q;
    regword_d = regword_q;
    dataword_d = dataword_q;
    writedata_d = writedata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (st_req) begin
        opcode_d = st_opcode;
        addr_d = st_addr;
        regword_d = st_regword;
        dataword_d = '0;
        err_d = bad;
        state_d = bad ? DONE : is_sw ? MERGE : RD_REQ;
      end
      RD_REQ: state_d = mem_waitrequest ? RD_REQ : RD_WAIT;
      RD_WAIT: begin
        dataword_d = mem_readdata;
        state_d = MERGE;
      end
      MERGE: begin
        writedata_d = merge_storedata;
        state_d = WR_REQ;
      end
      WR_REQ: state_d = mem_waitrequest ? WR_REQ : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      opcode_q <= '0;
      addr_q <= '0;
      regword_q <= '0;
      dataword_q <= '0;
      writedata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opcode_q <= opcode_d;
      addr_q <= addr_d;
      regword_q <= regword_d;
      dataword_q <= dataword_d;
      writedata_q <= writedata_d;
      err_q <= err_d;
    end
  end
  assign st_ready = state_q == IDLE;
  assign cpu_stall = state_q != IDLE;
  assign st_done = state_q == DONE;
  assign st_err = st_done && err_q;
  assign mem_read = state_q == RD_REQ;
  assign mem_write = state_q == WR_REQ;
  assign mem_address = {addr_q[31:2], 2'b00};
  assign mem_writedata = writedata_q;
  assign merge_opcode = opcode_q;
  assign merge_addr = addr_q;
  assign merge_regword = regword_q;
  assign merge_dataword = dataword_q;
endmodule

// File: tb/tb_store_access_ctrl.sv
// tb_store_access_ctrl: directed checks of store sequencing against a merge-unit and memory model.
module tb_store_access_ctrl;
  localparam logic [5:0] OP_SB = 6'b101000, OP_SH = 6'b101001, OP_SW = 6'b101011;
  logic clk = 0, reset = 1, st_req = 0;
  logic [5:0] st_opcode = '0;
  logic [31:0] st_addr = '0, st_regword = '0;
  logic st_ready, st_done, st_err, cpu_stall, mem_read, mem_write, mem_waitrequest;
  logic [5:0] merge_opcode;
  logic [31:0] merge_addr, merge_regword, merge_dataword, merge_storedata;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  int checks = 0, errors = 0;
  int rd_waits = 0, wr_waits = 0, rd_cnt = 0, wr_cnt = 0;
  logic [31:0] rd_val = '0;
  logic rd_valid = 0;
  int done_c, n_rd, n_wr, wr_c, req_cycles;
  logic err_o, both, unstable;
  logic [31:0] wdata_o;

  store_access_ctrl dut (.clk(clk), .reset(reset), .st_req(st_req), .st_opcode(st_opcode),
    .st_addr(st_addr), .st_regword(st_regword), .st_ready(st_ready), .st_done(st_done),
    .st_err(st_err), .cpu_stall(cpu_stall), .merge_opcode(merge_opcode), .merge_addr(merge_addr),
    .merge_regword(merge_regword), .merge_dataword(merge_dataword), .merge_storedata(merge_storedata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata));

  always #5 clk = ~clk;

  // Big-endian merge unit: byte offset 0 lives in bits 31:24.
  always_comb begin
    merge_storedata = merge_dataword;
    if (merge_opcode == OP_SB) merge_storedata[(3 - int'(merge_addr[1:0])) * 8 +: 8] = merge_regword[7:0];
    else if (merge_opcode == OP_SH && merge_addr[1]) merge_storedata[15:0] = merge_regword[15:0];
    else if (merge_opcode == OP_SH) merge_storedata[31:16] = merge_regword[15:0];
    else if (merge_opcode == OP_SW)
      merge_storedata = {merge_regword[7:0], merge_regword[15:8], merge_regword[23:16], merge_regword[31:24]};
  end

  assign mem_waitrequest = (mem_read && rd_cnt < rd_waits) || (mem_write && wr_cnt < wr_waits);
  assign mem_readdata = rd_valid ? rd_val : 32'h0;
  always @(posedge clk) begin
    rd_valid <= mem_read && !mem_waitrequest;
    rd_cnt <= !mem_read ? 0 : mem_waitrequest ? rd_cnt + 1 : rd_cnt;
    wr_cnt <= !mem_write ? 0 : mem_waitrequest ? wr_cnt + 1 : wr_cnt;
  end

  task automatic observe_cycle(input int c, input logic [5:0] op, input logic [31:0] a, input logic [31:0] r);
    if (mem_read && mem_write) both = 1;
    if (mem_read || mem_write) req_cycles++;
    if (mem_read && !mem_waitrequest) n_rd++;
    if (mem_write && !mem_waitrequest) begin
      n_wr++;
      wr_c = c;
      wdata_o = mem_writedata;
    end
    if (cpu_stall && (merge_opcode !== op || merge_addr !== a || merge_regword !== r ||
        mem_address !== {a[31:2], 2'b00})) unstable = 1;
    if (st_done && done_c < 0) begin
      done_c = c;
      err_o = st_err;
    end
  endtask

  task automatic do_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r,
                          input logic [31:0] rd, input int rw, input int ww);
    @(negedge clk);
    st_opcode = op; st_addr = a; st_regword = r; st_req = 1;
    rd_val = rd; rd_waits = rw; wr_waits = ww;
    done_c = -1; n_rd = 0; n_wr = 0; wr_c = -1; req_cycles = 0;
    err_o = 0; both = 0; unstable = 0; wdata_o = '0;
    @(posedge clk); #1 st_req = 0;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(negedge clk);
      observe_cycle(c, op, a, r);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({st_ready, st_done, st_err, cpu_stall, mem_read, mem_write} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000", {st_ready, st_done, st_err, cpu_stall, mem_read, mem_write});
    end
    checks++;
    if ({mem_address, mem_writedata, merge_addr, merge_regword, merge_dataword} !== '0 || merge_opcode !== '0) begin
      errors++;
      $display("FAIL reset_regs: addr %h wdata %h maddr %h mreg %h mdata %h mop %b expected all 0",
               mem_address, mem_writedata, merge_addr, merge_regword, merge_dataword, merge_opcode);
    end
    reset = 0;
  endtask

  task automatic test_sw;
    do_store(OP_SW, 32'h100, 32'h11223344, 32'h0, 0, 0);
    checks++;
    if (done_c !== 3 || err_o !== 0) begin
      errors++;
      $display("FAIL sw_done: cycle %0d err %b expected cycle 3 err 0", done_c, err_o);
    end
    checks++;
    if (wr_c !== 2 || n_wr !== 1 || n_rd !== 0 || wdata_o !== 32'h44332211) begin
      errors++;
      $display("FAIL sw_write: at %0d writes %0d reads %0d data %h expected at 2 writes 1 reads 0 data 44332211",
               wr_c, n_wr, n_rd, wdata_o);
    end
    checks++;
    if (unstable !== 0 || both !== 0) begin
      errors++;
      $display("FAIL sw_stable: unstable %b both %b expected 0 0", unstable, both);
    end
  endtask

  task automatic test_sb;
    do_store(OP_SB, 32'h105, 32'h000000AB, 32'hDEADBEEF, 0, 0);
    checks++;
    if (done_c !== 5 || err_o !== 0) begin
      errors++;
      $display("FAIL sb_done: cycle %0d err %b expected cycle 5 err 0", done_c, err_o);
    end
    checks++;
    if (n_rd !== 1 || n_wr !== 1 || wr_c !== 4 || wdata_o !== 32'hDEABBEEF) begin
      errors++;
      $display("FAIL sb_rmw: reads %0d writes %0d at %0d data %h expected 1 1 at 4 data DEABBEEF",
               n_rd, n_wr, wr_c, wdata_o);
    end
    checks++;
    if (unstable !== 0 || both !== 0) begin
      errors++;
      $display("FAIL sb_stable: unstable %b both %b expected 0 0 (mem_address 104)", unstable, both);
    end
  endtask

  task automatic test_sh_wait;
    do_store(OP_SH, 32'h22, 32'h00001234, 32'hCAFEF00D, 2, 1);
    checks++;
    if (done_c !== 8 || err_o !== 0) begin
      errors++;
      $display("FAIL sh_done: cycle %0d err %b expected cycle 8 err 0", done_c, err_o);
    end
    checks++;
    if (n_rd !== 1 || n_wr !== 1 || wr_c !== 7 || wdata_o !== 32'hCAFE1234 || req_cycles !== 5) begin
      errors++;
      $display("FAIL sh_rmw: reads %0d writes %0d at %0d data %h req_cycles %0d expected 1 1 at 7 data CAFE1234 req_cycles 5",
               n_rd, n_wr, wr_c, wdata_o, req_cycles);
    end
    checks++;
    if (unstable !== 0 || both !== 0) begin
      errors++;
      $display("FAIL sh_stable: unstable %b both %b expected 0 0", unstable, both);
    end
  endtask

  task automatic test_errors;
    logic [5:0] ops [3] = '{OP_SH, OP_SW, 6'b100011};
    logic [31:0] adrs [3] = '{32'h03, 32'h02, 32'h40};
    for (int i = 0; i < 3; i++) begin
      do_store(ops[i], adrs[i], 32'hFFFF0000, 32'h0, 0, 0);
      checks++;
      if (done_c !== 1 || err_o !== 1 || req_cycles !== 0) begin
        errors++;
        $display("FAIL err_case%0d: done %0d err %b req_cycles %0d expected done 1 err 1 req_cycles 0",
                 i, done_c, err_o, req_cycles);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic late_done = 0, late_stall = 0;
    @(negedge clk);
    st_opcode = OP_SW; st_addr = 32'h300; st_regword = 32'h01020304; st_req = 1;
    wr_waits = 3; rd_waits = 0;
    @(posedge clk); #1 st_req = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_write !== 1 || mem_waitrequest !== 1) begin
      errors++;
      $display("FAIL rst_mid_setup: mem_write %b wait %b expected 1 1", mem_write, mem_waitrequest);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (mem_write !== 0 || st_ready !== 1 || st_done !== 0) begin
      errors++;
      $display("FAIL rst_mid: mem_write %b st_ready %b st_done %b expected 0 1 0", mem_write, st_ready, st_done);
    end
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (st_done) late_done = 1;
      if (cpu_stall || mem_write) late_stall = 1;
    end
    checks++;
    if (late_done !== 0 || late_stall !== 0) begin
      errors++;
      $display("FAIL rst_mid_after: done %b busy %b expected 0 0", late_done, late_stall);
    end
    do_store(OP_SW, 32'h40, 32'hCAFEBABE, 32'h0, 0, 0);
    checks++;
    if (done_c !== 3 || err_o !== 0 || wdata_o !== 32'hBEBAFECA) begin
      errors++;
      $display("FAIL rst_mid_next_sw: done %0d err %b data %h expected 3 0 BEBAFECA", done_c, err_o, wdata_o);
    end
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, idle_cycles = 0, w1 = -1, w2 = -1;
    logic [31:0] data1 = '0, data2 = '0;
    @(negedge clk);
    st_opcode = OP_SB; st_addr = 32'h105; st_regword = 32'h000000AB; st_req = 1;
    rd_val = 32'hDEADBEEF; rd_waits = 0; wr_waits = 0;
    @(posedge clk);
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        st_opcode = OP_SW; st_addr = 32'h200; st_regword = 32'hA1B2C3D4;
      end
      if (d1 >= 0 && cpu_stall) st_req = 0;
      if (!cpu_stall) idle_cycles++;
      if (mem_write && !mem_waitrequest) begin
        if (w1 < 0) begin w1 = c; data1 = mem_writedata; end
        else begin w2 = c; data2 = mem_writedata; end
      end
      if (st_done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
    end
    st_req = 0;
    checks++;
    if (d1 !== 5 || d2 !== 9) begin
      errors++;
      $display("FAIL b2b_done: first %0d second %0d expected 5 9", d1, d2);
    end
    checks++;
    if (idle_cycles !== 1) begin
      errors++;
      $display("FAIL b2b_idle: low-stall cycles %0d expected 1", idle_cycles);
    end
    checks++;
    if (w1 !== 4 || data1 !== 32'hDEABBEEF || w2 !== 8 || data2 !== 32'hD4C3B2A1) begin
      errors++;
      $display("FAIL b2b_writes: %0d:%h %0d:%h expected 4:DEABBEEF 8:D4C3B2A1", w1, data1, w2, data2);
    end
  endtask

  initial begin
    test_reset;
    test_sw;
    test_sb;
    test_sh_wait;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_access_ctrl.md
# store_access_ctrl

Sequencer for all CPU store traffic (sb, sh, sw) between the execute stage, the external store-merge unit and the data-memory bus. A full-word store goes straight to memory. A partial store is done as read-modify-write: read the target word, hand it to the merge unit, write the merged word back. The block stalls the pipeline while busy and flags misaligned stores without touching memory.

## Interface
- No parameters; data and address widths fixed at 32.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- st_req  in  1  store request from execute stage; qualified by st_ready.
- st_opcode  in  6  101000 sb, 101001 sh, 101011 sw; other values rejected as error.
- st_addr  in  32  effective byte address.
- st_regword  in  32  source register value.
- st_ready  out  1  high only in IDLE.
- st_done  out  1  one-cycle pulse on completion, success or error.
- st_err  out  1  valid with st_done; 1 = misaligned or illegal opcode.
- cpu_stall  out  1  high in every non-IDLE state.
- merge_opcode  out  6  latched opcode to merge unit.
- merge_addr  out  32  latched address to merge unit.
- merge_regword  out  32  latched regword to merge unit.
- merge_dataword  out  32  word read from memory (0 for sw).
- merge_storedata  in  32  combinational merge result.
- mem_address  out  32  word address: {addr[31:2], 2'b00}.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  registered merged word.
- mem_waitrequest  in  1  slave stall; request held while high.
- mem_readdata  in  32  valid exactly one cycle after a read is accepted.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, MERGE, WR_REQ, DONE.
- **IDLE:** on st_req, latch opcode, address and regword. Check alignment:
  - sh: addr[0] must be 0.
  - sw: addr[1:0] must be 00.
  - sb: always aligned.
  - Illegal or misaligned → DONE with err=1. Otherwise sb/sh → RD_REQ, sw → MERGE.
- **RD_REQ:** mem_read=1. Held while mem_waitrequest=1. Acceptance (waitrequest=0) → RD_WAIT.
- **RD_WAIT:** capture mem_readdata into the dataword register → MERGE.
- **MERGE:** register merge_storedata into mem_writedata → WR_REQ.
- **WR_REQ:** mem_write=1. Held while waitrequest=1. Acceptance → DONE.
- **DONE:** st_done=1 for one cycle → IDLE.
- mem_read and mem_write are never high together and never high outside RD_REQ / WR_REQ.
- mem_address, mem_writedata and all merge_* outputs are stable for the whole transaction.
- Merge-unit contract (big-endian lanes, byte offset 0 = bits 31:24):
  - sb places regword[7:0] in the lane selected by addr[1:0].
  - sh places regword[15:0] in [31:16] (offset 0) or [15:0] (offset 2).
  - sw writes regword byte-reversed.

## Timing
- Reset values:
  - State IDLE, so st_ready=1.
  - st_done, st_err, cpu_stall, mem_read, mem_write = 0.
  - All data and address registers = 0.
- Reset mid-transaction: next edge returns to IDLE, request lines drop, no st_done. The bus transaction is abandoned.
- Latency with waitrequest held 0, request accepted at edge 0:
  - sw: MERGE c1, WR_REQ c2, DONE c3.
  - sb/sh: RD_REQ c1, RD_WAIT c2, MERGE c3, WR_REQ c4, DONE c5.
  - Error: DONE c1.
- Each waitrequest-high cycle adds exactly one cycle.
- st_req while busy is ignored; the requester holds it until st_ready.
- Back-to-back: a new request can be accepted in the cycle after DONE.

## Test plan
- **sw, no wait:** addr 0x100, regword 0x11223344 → mem_write at c2, mem_address 0x100, writedata 0x44332211, st_done at c3 with err=0, zero reads.
- **sb, RMW:** addr 0x105, regword 0xAB, memory returns 0xDEADBEEF → read at 0x104, write 0xDEABBEEF, st_done at c5.
- **sh, 2 waitrequest cycles on read and 1 on write:** addr 0x22, regword 0x1234, memory returns 0xCAFEF00D → write 0xCAFE1234, st_done at c8; address stable throughout.
- **Misaligned / illegal:** sh at 0x03, sw at 0x02, opcode 100011 → each gives st_done and st_err at c1, and mem_read/mem_write never asserted.
- **Reset in WR_REQ with waitrequest=1:** next cycle mem_write=0, st_ready=1, no st_done. A following sw completes normally.
- **Back-to-back:** sb then sw with st_req held → second accepted the cycle after the first DONE. cpu_stall is low for exactly that one IDLE cycle between the two.
